// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory req/ack port of the memory pipeline stage
// The stage is the master; the memory answers with ack and read data in the same cycle.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: sized load/store over req/ack with timeout
// Consumes X/M registers, stalls upstream while a request is outstanding, produces M/W.
module mem_stage #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        xm_valid_in,
  input  logic [31:0] XM_O,
  input  logic [31:0] XM_B,
  input  logic [31:0] XM_IR,
  input  logic        mem_rw_in,
  input  logic        mem_out_sel_in,
  input  logic [1:0]  mem_access_size_in,
  input  logic        wb_we_in,
  input  logic [4:0]  wb_reg_addr_in,
  mem_stage_if.master dmem,
  output logic        stall_out,
  output logic [31:0] MW_O,
  output logic [31:0] MW_IR,
  output logic        wb_we_out,
  output logic [4:0]  wb_reg_addr_out,
  output logic        mw_valid_out,
  output logic        fault_out
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_REQ   = 1'b1;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q, o_q, ir_q;
  logic [3:0]       be_q;
  logic [1:0]       size_q, off_q;
  logic             we_q, sel_q, wb_we_q;
  logic [4:0]       dest_q;

  logic        mem_op, misaligned, start, timeout, in_req;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, load_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign mem_op  = xm_valid_in & (mem_rw_in | mem_out_sel_in);
  assign in_req  = (state == S_REQ);
  assign start   = (state == S_IDLE) & mem_op & ~misaligned;
  assign timeout = in_req & ~dmem.dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));
  assign stall_out = start | (in_req & ~dmem.dmem_ack);

  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = XM_B;
    case (mem_access_size_in)
      SZ_BYTE: begin
        be_next    = 4'b1000 >> XM_O[1:0];
        wdata_next = {4{XM_B[7:0]}};
      end
      SZ_HALF: begin
        misaligned = XM_O[0];
        be_next    = XM_O[1] ? 4'b0011 : 4'b1100;
        wdata_next = {2{XM_B[15:0]}};
      end
      default: misaligned = |XM_O[1:0];
    endcase
  end

  // Big-endian lanes: offset 0 selects the most significant byte/half.
  always_comb begin
    byte_v   = 8'(dmem.dmem_rdata >> {~off_q, 3'b000});
    half_v   = off_q[1] ? dmem.dmem_rdata[15:0] : dmem.dmem_rdata[31:16];
    load_val = dmem.dmem_rdata;
    case (size_q)
      SZ_BYTE: load_val = ir_q[28] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_val = ir_q[28] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  assign dmem.dmem_req   = in_req;
  assign dmem.dmem_we    = in_req & we_q;
  assign dmem.dmem_be    = in_req ? be_q : 4'b0000;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= S_IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      o_q             <= '0;
      ir_q            <= '0;
      be_q            <= '0;
      size_q          <= '0;
      off_q           <= '0;
      we_q            <= 1'b0;
      sel_q           <= 1'b0;
      wb_we_q         <= 1'b0;
      dest_q          <= '0;
      MW_O            <= '0;
      MW_IR           <= '0;
      wb_we_out       <= 1'b0;
      wb_reg_addr_out <= '0;
      mw_valid_out    <= 1'b0;
      fault_out       <= 1'b0;
    end else begin
      fault_out <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            state        <= S_REQ;
            addr_q       <= {XM_O[31:2], 2'b00};
            wdata_q      <= wdata_next;
            be_q         <= be_next;
            we_q         <= mem_rw_in;
            sel_q        <= mem_out_sel_in;
            size_q       <= mem_access_size_in;
            off_q        <= XM_O[1:0];
            o_q          <= XM_O;
            ir_q         <= XM_IR;
            wb_we_q      <= wb_we_in;
            dest_q       <= wb_reg_addr_in;
            mw_valid_out <= 1'b0;
            wb_we_out    <= 1'b0;
          end else if (mem_op) begin
            // misaligned: retire immediately as a faulting, non-writing instruction
            MW_O            <= XM_O;
            MW_IR           <= XM_IR;
            wb_reg_addr_out <= wb_reg_addr_in;
            wb_we_out       <= 1'b0;
            mw_valid_out    <= 1'b1;
            fault_out       <= 1'b1;
          end else if (xm_valid_in) begin
            MW_O            <= XM_O;
            MW_IR           <= XM_IR;
            wb_reg_addr_out <= wb_reg_addr_in;
            wb_we_out       <= wb_we_in;
            mw_valid_out    <= 1'b1;
          end else begin
            wb_we_out    <= 1'b0;
            mw_valid_out <= 1'b0;
          end
        end
        default: begin
          if (dmem.dmem_ack) begin
            state           <= S_IDLE;
            cnt             <= '0;
            MW_O            <= sel_q ? load_val : o_q;
            MW_IR           <= ir_q;
            wb_reg_addr_out <= dest_q;
            wb_we_out       <= wb_we_q & ~we_q;
            mw_valid_out    <= 1'b1;
          end else if (timeout) begin
            state           <= S_IDLE;
            cnt             <= '0;
            MW_IR           <= ir_q;
            wb_reg_addr_out <= dest_q;
            wb_we_out       <= 1'b0;
            mw_valid_out    <= 1'b1;
            fault_out       <= 1'b1;
          end else begin
            cnt          <= cnt + 1'b1;
            wb_we_out    <= 1'b0;
            mw_valid_out <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
